i2c_master: RTL and testbench



---
 rtl/i2c_master_if.sv | 16 +
 rtl/i2c_master.sv | 122 ++++++++++++
 tb/tb_i2c_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_if.sv
// i2c_master_if: host-side request/response handshake of the I2C initiator
// master modport: the controlling logic (drives start and transaction fields)
// slave modport : the i2c_master block (returns rdata, busy, done, ack_err)
interface i2c_master_if;
    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    modport master (output start, dev_addr, reg_addr, rw, wdata, input rdata, busy, done, ack_err);
    modport slave (input start, dev_addr, reg_addr, rw, wdata, output rdata, busy, done, ack_err);
endinterface

// File: rtl/i2c_master.sv
// i2c_master: single-transaction I2C initiator, one register byte written or read per start
// Ports: clk, rst (sync, active-high); host (i2c_master_if.slave: start, dev_addr, reg_addr,
// rw, wdata -> rdata, busy, done, ack_err); scl (push-pull); sda (open-drain, low or z).
// Option: define I2C_RSTART_EN for the combined format (write address, repeated START,
// read address) on reads; otherwise a read sends R=1 in the first address byte.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    i2c_master_if.slave host,
    output logic        scl,
    inout  wire         sda
);
`ifdef I2C_RSTART_EN
    localparam bit RSTART_EN = 1'b1;
`else
    localparam bit RSTART_EN = 1'b0;
`endif
    typedef enum logic [3:0] {
        IDLE, START, ADDR, A1, REG, A2, WDATA, A3,
        RSTART, ADDR2, A4, RDATA, MNACK, STOP, DONE
    } state_t;
    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  ph;
    logic [2:0]  bcnt;
    logic [7:0]  sh, reg_q, wdata_q;
    logic [6:0]  dev_q;
    logic        rw_q, err, smp, sda_low;
    logic        tick, bit_end, bit_in, last, tx_st, byte_st, scl_n, low_n;
    assign sda = sda_low ? 1'b0 : 1'bz;
    // Pins are registered from the current state, so the bus trails the state by one cycle.
    // The pin-level "last cycle of phase 2" is therefore the first state cycle of phase 3;
    // with CLK_DIV=1 that is also the bit-end cycle, so the live pin is used directly.
    always_comb begin
        tick    = cnt == 16'(CLK_DIV - 1);
        bit_end = tick && ph == 2'd3;
        bit_in  = (cnt == 16'd0) ? sda : smp;
        last    = bcnt == 3'd7;
        tx_st   = state inside {ADDR, REG, WDATA, ADDR2};
        byte_st = tx_st || state == RDATA;
        scl_n   = (state == IDLE || state == START || state == DONE) ? 1'b1 : ph[1];
        low_n   = (state == START)  ? ph[1] :
                  (state == RSTART) ? (ph == 2'd3) :
                  (state == STOP)   ? (ph != 2'd3) :
                  tx_st ? ~sh[7] : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ph           <= '0;
            bcnt         <= '0;
            sh           <= '0;
            dev_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            err          <= 1'b0;
            smp          <= 1'b1;
            scl          <= 1'b1;
            sda_low      <= 1'b0;
            host.busy    <= 1'b0;
            host.done    <= 1'b0;
            host.ack_err <= 1'b0;
            host.rdata   <= '0;
        end else begin
            scl       <= scl_n;
            sda_low   <= low_n;
            host.done <= 1'b0;
            if (state == IDLE) begin
                if (host.start) begin
                    state        <= START;
                    dev_q        <= host.dev_addr;
                    reg_q        <= host.reg_addr;
                    wdata_q      <= host.wdata;
                    rw_q         <= host.rw;
                    err          <= 1'b0;
                    cnt          <= '0;
                    ph           <= '0;
                    host.busy    <= 1'b1;
                    host.ack_err <= 1'b0;
                end
            end else if (state == DONE) begin
                state        <= IDLE;
                host.busy    <= 1'b0;
                host.done    <= 1'b1;
                host.ack_err <= err;
            end else begin
                cnt <= tick ? '0 : cnt + 16'd1;
                if (tick) ph <= ph + 2'd1;
                if (ph == 2'd3 && cnt == 16'd0) smp <= sda;
                if (bit_end) begin
                    // bcnt wraps to 0 after eight data bits and is held at 0 elsewhere
                    bcnt <= byte_st ? bcnt + 3'd1 : 3'd0;
                    sh   <= {sh[6:0], bit_in};
                    case (state)
                        START:  begin state <= ADDR; sh <= {dev_q, rw_q & ~RSTART_EN}; end
                        ADDR:   if (last) state <= A1;
                        REG:    if (last) state <= A2;
                        WDATA:  if (last) state <= A3;
                        ADDR2:  if (last) state <= A4;
                        RDATA:  if (last) begin state <= MNACK; host.rdata <= {sh[6:0], bit_in}; end
                        A1:     if (bit_in) begin err <= 1'b1; state <= STOP; end
                                else begin state <= REG; sh <= reg_q; end
                        A2:     if (bit_in) begin err <= 1'b1; state <= STOP; end
                                else if (!rw_q) begin state <= WDATA; sh <= wdata_q; end
                                else state <= RSTART_EN ? RSTART : RDATA;
                        A3:     begin err <= err | bit_in; state <= STOP; end
                        A4:     if (bit_in) begin err <= 1'b1; state <= STOP; end
                                else state <= RDATA;
                        RSTART: begin state <= ADDR2; sh <= {dev_q, 1'b1}; end
                        MNACK:  state <= STOP;
                        STOP:   state <= DONE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed scoreboard bench with a behavioural I2C responder at 7'h6D
module tb_i2c_master;
    localparam int CD = 4;
    localparam logic [6:0] RESP = 7'h6D;
`ifdef I2C_RSTART_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cycles;
        int         starts;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl;
    wire  sda;
    i2c_master_if hif ();
    i2c_master #(.CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .host(hif), .scl(scl), .sda(sda));
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, n_done = 0, n_starts = 0, starts0 = 0;
    exp_t sb[$];
    logic [7:0] exp_bytes[$], mon_bytes[$];
    logic [7:0] model_rdata = 8'h00;

    always @(posedge clk) if (!rst && hif.done) n_done++;

    // responder: samples on SCL rise, drives on SCL fall, detects START/STOP on SDA edges
    logic r_low = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
    logic r_sel = 1'b0, r_rd = 1'b0, r_have_ptr = 1'b0, r_tx_on = 1'b0, r_tx_next = 1'b0;
    logic [3:0] r_cnt = 4'd0;
    int r_byte = -1;
    logic [7:0] r_sh = 8'h00, r_tx = 8'h00, r_ptr = 8'h00;
    logic [7:0] mem [256];
    assign sda = r_low ? 1'b0 : 1'bz;
    pullup (sda);

    always @(scl or sda) begin
        if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
            n_starts++;
            r_cnt = 4'd0; r_byte = 0; r_low = 1'b0; r_tx_on = 1'b0; r_tx_next = 1'b0;
        end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
            r_byte = -1; r_low = 1'b0; r_tx_on = 1'b0; r_have_ptr = 1'b0;
        end else if (p_scl === 1'b0 && scl === 1'b1) begin
            if (r_byte >= 0) begin
                if (r_cnt < 4'd8) r_sh = {r_sh[6:0], sda === 1'b1};
                r_cnt++;
            end
        end else if (p_scl === 1'b1 && scl === 1'b0 && r_byte >= 0) begin
            if (r_cnt == 4'd8) begin
                mon_bytes.push_back(r_sh);
                r_low = 1'b0;
                r_tx_next = 1'b0;
                if (!r_tx_on) begin
                    if (r_byte == 0) begin
                        r_sel = r_sh[7:1] == RESP;
                        r_rd = r_sh[0];
                        r_low = r_sel;
                        r_tx_next = r_sel && r_rd && r_have_ptr;
                    end else if (r_sel && r_byte == 1) begin
                        r_ptr = r_sh; r_have_ptr = 1'b1; r_low = 1'b1; r_tx_next = r_rd;
                    end else if (r_sel && r_byte == 2 && !r_rd) begin
                        mem[r_ptr] = r_sh; r_low = 1'b1;
                    end
                end
            end else if (r_cnt == 4'd9) begin
                r_cnt = 4'd0;
                r_byte++;
                r_tx_on = r_tx_next;
                r_tx = mem[r_ptr];
                r_low = r_tx_next && !r_tx[7];
            end else if (r_tx_on && r_cnt > 4'd0) begin
                r_tx = r_tx << 1;
                r_low = !r_tx[7];
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic launch(input logic [6:0] d, input logic [7:0] r, input logic rwv, input logic [7:0] wd);
        exp_t e;
        logic ack;
        ack = d == RESP;
        exp_bytes.push_back({d, rwv & ~RS});
        if (ack) begin
            exp_bytes.push_back(r);
            if (rwv && RS) exp_bytes.push_back({d, 1'b1});
            exp_bytes.push_back(rwv ? mem[r] : wd);
        end
        e.rdata = (ack && rwv) ? mem[r] : model_rdata;
        e.err = !ack;
        e.cycles = 4 * CD * (!ack ? 11 : (rwv && RS) ? 39 : 29) + 1;
        e.starts = (ack && rwv && RS) ? 2 : 1;
        sb.push_back(e);
        starts0 = n_starts;
        hif.dev_addr = d; hif.reg_addr = r; hif.rw = rwv; hif.wdata = wd; hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        cyc = 0;
        chk("busy_after_start", hif.busy, 1);
        chk("ack_err_cleared", hif.ack_err, 0);
    endtask

    task automatic finish_txn(input string tag);
        exp_t e;
        while (hif.done !== 1'b1 && cyc < 3000) step(1);
        e = sb.pop_front();
        chk({tag, ".cycles"}, cyc, e.cycles);
        chk({tag, ".rdata"}, hif.rdata, e.rdata);
        chk({tag, ".ack_err"}, hif.ack_err, e.err);
        chk({tag, ".busy_at_done"}, hif.busy, 0);
        chk({tag, ".starts"}, n_starts - starts0, e.starts);
        chk({tag, ".nbytes"}, mon_bytes.size(), exp_bytes.size());
        while (mon_bytes.size() > 0 && exp_bytes.size() > 0)
            chk({tag, ".byte"}, mon_bytes.pop_front(), exp_bytes.pop_front());
        mon_bytes.delete();
        exp_bytes.delete();
        model_rdata = e.rdata;
        step(1);
        chk({tag, ".done_pulse"}, hif.done, 0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h4A] = 8'h1D;
        hif.start = 1'b0; hif.dev_addr = '0; hif.reg_addr = '0; hif.rw = 1'b0; hif.wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(2);
        chk("rst.scl", scl, 1);
        chk("rst.sda", sda, 1);
        chk("rst.busy", hif.busy, 0);
        chk("rst.done", hif.done, 0);
        chk("rst.ack_err", hif.ack_err, 0);
        chk("rst.rdata", hif.rdata, 8'h00);

        launch(RESP, 8'h4A, 1'b1, 8'h00);
        finish_txn("read1");

        launch(RESP, 8'h4A, 1'b0, 8'hA5);
        finish_txn("write");
        chk("write.mem", mem[8'h4A], 8'hA5);

        d0 = n_done;
        launch(RESP, 8'h4A, 1'b1, 8'h00);
        step(50);
        hif.dev_addr = 7'h12; hif.rw = 1'b0; hif.start = 1'b1;
        step(1);
        hif.start = 1'b0;
        finish_txn("read_poke");
        step(200);
        chk("poke.ndone", n_done - d0, 1);

        launch(7'h12, 8'h4A, 1'b1, 8'h00);
        finish_txn("nack");
        step(20);
        chk("nack.ack_err_held", hif.ack_err, 1);

        launch(RESP, 8'h4A, 1'b1, 8'h00);
        step(12 * 4 * CD + 6);
        rst = 1'b1;
        step(1);
        chk("midrst.scl", scl, 1);
        chk("midrst.sda", sda, 1);
        chk("midrst.busy", hif.busy, 0);
        chk("midrst.rdata", hif.rdata, 8'h00);
        rst = 1'b0;
        void'(sb.pop_front());
        mon_bytes.delete();
        exp_bytes.delete();
        model_rdata = 8'h00;
        step(10);
        launch(RESP, 8'h4A, 1'b1, 8'h00);
        finish_txn("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
